cds_sequencer: RTL and testbench

//  Per-pixel CDS timing generator; sits directly upstream of pixel_processor and drives its CDSBUS[7:0].

---
 rtl/cds_seq_pkg.sv | 44 ++++
 rtl/cds_pulse_gen.sv | 71 +++++++
 rtl/cds_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cds_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cds_seq_pkg.sv
// Shared constants, state encoding and helpers for the CDS timing sequencer.
// Compile-time option CDS_SEQ_MARKER_EN is consumed by cds_sequencer.
package cds_seq_pkg;

    localparam logic [16:0] SETTLE     = 17'd8;
    localparam logic [15:0] DEF_WINDOW = 16'd200;
    localparam logic [15:0] DEF_PERIOD = 16'd1024;
    localparam logic [15:0] DEF_NPIX   = 16'd1;
    localparam logic [7:0]  DEF_DIV    = 8'd4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_INTEG = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;
    localparam logic [2:0] ST_ABORT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_INTEG = ST_INTEG,
        S_READ  = ST_READ,
        S_GAP   = ST_GAP,
        S_FIN   = ST_FIN,
        S_ABORT = ST_ABORT
    } cds_state_e;

    localparam int CDS_BIT_STROBE = 0;
    localparam int CDS_BIT_END    = 3;
    localparam int CDS_BIT_START  = 5;
    localparam int CDS_BIT_MARK   = 7;
    localparam int RD_LAT         = 2;

    // Readout spacing below 2 would leave bit5 permanently high.
    function automatic logic [7:0] eff_div(input logic [7:0] div);
        if (div < 8'd2) begin
            return 8'd2;
        end else begin
            return div;
        end
    endfunction

endpackage

// File: rtl/cds_pulse_gen.sv
// Readout pulse generator: divider plus RD_LAT-deep delay line producing the
// bit5 read-advance pulses and the bit0 output strobes. Exposes next-cycle values.
module cds_pulse_gen
    import cds_seq_pkg::*;
(
    input  logic        clk_muestra,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [7:0]  div,
    input  logic [15:0] window,
    output logic        rise,
    output logic        strobe,
    output logic        rise_nxt,
    output logic        strobe_nxt,
    output logic [15:0] pulse_count
);

    logic [7:0]        div_cnt_r, div_cnt_s;
    logic [15:0]       cnt_r, cnt_s;
    logic              rise_r, rise_s;
    logic [RD_LAT-1:0] dly_r, dly_s;

    // Next-state of divider, pulse counter and delay line.
    always_comb begin
        div_cnt_s = div_cnt_r;
        cnt_s     = cnt_r;
        rise_s    = rise_r;
        dly_s     = dly_r;
        if (clr) begin
            // Parked one step before wrap so the first enabled cycle is a pulse.
            div_cnt_s = div - 8'd1;
            cnt_s     = 16'd0;
            rise_s    = 1'b0;
            dly_s     = '0;
        end else if (en) begin
            if (div_cnt_r >= div - 8'd1) begin
                div_cnt_s = 8'd0;
            end else begin
                div_cnt_s = div_cnt_r + 8'd1;
            end
            rise_s = (div_cnt_s == 8'd0) && (cnt_r < window);
            cnt_s  = cnt_r + {15'd0, rise_s};
            dly_s  = {dly_r[RD_LAT-2:0], rise_r};
        end else begin
            div_cnt_s = div_cnt_r;
        end
    end

    // Pulse generator state registers.
    always_ff @(posedge clk_muestra) begin
        if (reset) begin
            div_cnt_r <= 8'd0;
            cnt_r     <= 16'd0;
            rise_r    <= 1'b0;
            dly_r     <= '0;
        end else begin
            div_cnt_r <= div_cnt_s;
            cnt_r     <= cnt_s;
            rise_r    <= rise_s;
            dly_r     <= dly_s;
        end
    end

    assign rise        = rise_r;
    assign strobe      = dly_r[RD_LAT-1];
    assign rise_nxt    = rise_s;
    assign strobe_nxt  = dly_s[RD_LAT-1];
    assign pulse_count = cnt_r;

endmodule

// File: rtl/cds_sequencer.sv
// CDS sequencer top: frame FSM, shadow config, period/pixel counters, registered CDS bus.
// Define CDS_SEQ_MARKER_EN to flag the START cycle of pixel 0 on cdsbus[7].
module cds_sequencer
    import cds_seq_pkg::*;
(
    input  logic        clk_muestra,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        cfg_load,
    input  logic [15:0] cfg_window,
    input  logic [15:0] cfg_period,
    input  logic [15:0] cfg_npix,
    input  logic [7:0]  cfg_div,
    output logic [7:0]  cdsbus,
    output logic        busy,
    output logic [15:0] pix_count,
    output logic        done
);

    cds_state_e  state_r, state_s;
    logic [15:0] win_r, per_r, npix_r;
    logic [7:0]  div_r;
    logic [15:0] period_cnt_r;
    logic [16:0] integ_cnt_r;
    logic [15:0] pix_r, pix_s;
    logic [7:0]  cdsbus_r, cdsbus_s;
    logic        busy_r, done_r;

    logic        pg_en_s, pg_clr_s;
    logic        pg_rise_s, pg_strobe_s, pg_rise_nxt_s, pg_strobe_nxt_s;
    logic [15:0] pg_count_s;
    logic        read_last_s, gap_done_s, last_pix_s, abortable_s;

    assign pg_en_s  = (state_s == S_READ);
    assign pg_clr_s = ~pg_en_s;

    cds_pulse_gen u_pulse_gen (
        .clk_muestra (clk_muestra),
        .reset       (reset),
        .en          (pg_en_s),
        .clr         (pg_clr_s),
        .div         (div_r),
        .window      (win_r),
        .rise        (pg_rise_s),
        .strobe      (pg_strobe_s),
        .rise_nxt    (pg_rise_nxt_s),
        .strobe_nxt  (pg_strobe_nxt_s),
        .pulse_count (pg_count_s)
    );

    // READ is over once the strobe of the final pulse is on the bus.
    assign read_last_s = (win_r == 16'd0) ||
                         (pg_strobe_s && !pg_rise_s && (pg_count_s == win_r));
    assign gap_done_s  = (period_cnt_r >= per_r);
    assign last_pix_s  = (pix_r == npix_r - 16'd1);
    assign abortable_s = (state_r == S_START) || (state_r == S_INTEG) ||
                         (state_r == S_READ)  || (state_r == S_GAP);

    // Next-state and pixel index logic.
    always_comb begin
        state_s = state_r;
        pix_s   = pix_r;
        case (state_r)
            S_IDLE: begin
                if (start && (npix_r != 16'd0)) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: state_s = S_INTEG;
            S_INTEG: begin
                if (integ_cnt_r >= ({1'b0, win_r} + SETTLE)) begin
                    state_s = S_READ;
                end else begin
                    state_s = S_INTEG;
                end
            end
            S_READ, S_GAP: begin
                if ((state_r == S_READ) && !read_last_s) begin
                    state_s = S_READ;
                end else if (!gap_done_s) begin
                    state_s = S_GAP;
                end else if (last_pix_s) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_START;
                    pix_s   = pix_r + 16'd1;
                end
            end
            S_FIN:   state_s = S_IDLE;
            S_ABORT: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
        if (abort && abortable_s) begin
            state_s = S_ABORT;
        end else begin
            state_s = state_s;
        end
        if ((state_s == S_IDLE) || (state_s == S_FIN) || (state_s == S_ABORT)) begin
            pix_s = 16'd0;
        end else begin
            pix_s = pix_s;
        end
    end

    // CDS bus value for the coming cycle.
    always_comb begin
        cdsbus_s = 8'h00;
        if (state_s == S_ABORT) begin
            cdsbus_s = 8'h08;
        end else begin
            cdsbus_s[CDS_BIT_START]  = (state_s == S_START) || pg_rise_nxt_s;
            cdsbus_s[CDS_BIT_STROBE] = pg_strobe_nxt_s;
            cdsbus_s[CDS_BIT_END]    = (state_r == S_READ) && (state_s != S_READ);
`ifdef CDS_SEQ_MARKER_EN
            cdsbus_s[CDS_BIT_MARK]   = (state_s == S_START) && (pix_s == 16'd0);
`else
            cdsbus_s[CDS_BIT_MARK]   = 1'b0;
`endif
        end
    end

    // FSM state, pixel index and registered outputs.
    always_ff @(posedge clk_muestra) begin
        if (reset) begin
            state_r  <= S_IDLE;
            pix_r    <= 16'd0;
            cdsbus_r <= 8'h00;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pix_r    <= pix_s;
            cdsbus_r <= cdsbus_s;
            busy_r   <= (state_s != S_IDLE);
            done_r   <= (state_s == S_FIN) || (state_s == S_ABORT);
        end
    end

    // Shadow configuration, writable only while idle.
    always_ff @(posedge clk_muestra) begin
        if (reset) begin
            win_r  <= DEF_WINDOW;
            per_r  <= DEF_PERIOD;
            npix_r <= DEF_NPIX;
            div_r  <= DEF_DIV;
        end else if ((state_r == S_IDLE) && cfg_load) begin
            win_r  <= cfg_window;
            per_r  <= cfg_period;
            npix_r <= cfg_npix;
            div_r  <= eff_div(cfg_div);
        end else begin
            div_r  <= div_r;
        end
    end

    // Period counter holds cycles elapsed since START, inclusive of the current one.
    always_ff @(posedge clk_muestra) begin
        if (reset) begin
            period_cnt_r <= 16'd0;
            integ_cnt_r  <= 17'd0;
        end else begin
            if (state_s == S_START) begin
                period_cnt_r <= 16'd1;
            end else if (period_cnt_r != 16'hFFFF) begin
                period_cnt_r <= period_cnt_r + 16'd1;
            end else begin
                period_cnt_r <= period_cnt_r;
            end
            if (state_r == S_START) begin
                integ_cnt_r <= 17'd1;
            end else if (state_r == S_INTEG) begin
                integ_cnt_r <= integ_cnt_r + 17'd1;
            end else begin
                integ_cnt_r <= integ_cnt_r;
            end
        end
    end

    assign cdsbus    = cdsbus_r;
    assign busy      = busy_r;
    assign pix_count = pix_r;
    assign done      = done_r;

endmodule

// File: tb/tb_cds_sequencer.sv
// Directed self-checking bench for cds_sequencer; cycle 0 is the START cycle of a frame.
// Honours CDS_SEQ_MARKER_EN for the expected bit7 marker.
module tb_cds_sequencer;

`ifdef CDS_SEQ_MARKER_EN
    localparam logic [7:0] MARK = 8'h80;
`else
    localparam logic [7:0] MARK = 8'h00;
`endif
    localparam logic [7:0] START_EXP = 8'h20 | MARK;

    logic        clk_muestra = 1'b0;
    logic        reset, start, abort, cfg_load;
    logic [15:0] cfg_window, cfg_period, cfg_npix;
    logic [7:0]  cfg_div;
    logic [7:0]  cdsbus;
    logic        busy, done;
    logic [15:0] pix_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  bus_t  [0:127];
    logic        done_t [0:127];
    logic        busy_t [0:127];
    logic [15:0] pix_t  [0:127];

    cds_sequencer dut (
        .clk_muestra (clk_muestra),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_load    (cfg_load),
        .cfg_window  (cfg_window),
        .cfg_period  (cfg_period),
        .cfg_npix    (cfg_npix),
        .cfg_div     (cfg_div),
        .cdsbus      (cdsbus),
        .busy        (busy),
        .pix_count   (pix_count),
        .done        (done)
    );

    always #5 clk_muestra = ~clk_muestra;

    task automatic step();
        @(posedge clk_muestra);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_cfg(input logic [15:0] w, input logic [15:0] p,
                            input logic [15:0] n, input logic [7:0] d);
        cfg_window = w;
        cfg_period = p;
        cfg_npix   = n;
        cfg_div    = d;
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            bus_t[i]  = cdsbus;
            done_t[i] = done;
            busy_t[i] = busy;
            pix_t[i]  = pix_count;
            step();
        end
    endtask

    task automatic run_frame(input int n);
        start = 1'b1;
        step();
        start = 1'b0;
        capture(n);
    endtask

    function automatic logic [63:0] bit_mask(input int b, input int n);
        logic [63:0] m;
        m = 64'd0;
        for (int i = 0; i < n && i < 64; i++) m[i] = bus_t[i][b];
        return m;
    endfunction

    function automatic int bit_count(input int b, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (bus_t[i][b]) c++;
        return c;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (done_t[i]) return i;
        return -1;
    endfunction

    function automatic int done_count(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (done_t[i]) c++;
        return c;
    endfunction

    function automatic logic [7:0] bus_or(input int lo, input int hi);
        logic [7:0] v;
        v = 8'h00;
        for (int i = lo; i <= hi; i++) v = v | bus_t[i];
        return v;
    endfunction

    initial begin
        int done_at;
        int n5;
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_load = 1'b0;
        cfg_window = 16'd0; cfg_period = 16'd0; cfg_npix = 16'd0; cfg_div = 8'd0;
        step();
        step();
        check("rst_bus",  {56'd0, cdsbus}, 64'h00);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_pix",  {48'd0, pix_count}, 64'd0);
        reset = 1'b0;

        // 1: single pixel, window 4, period 40, div 3
        load_cfg(16'd4, 16'd40, 16'd1, 8'd3);
        run_frame(45);
        check("t1_start",  {56'd0, bus_t[0]}, {56'd0, START_EXP});
        check("t1_integ",  {56'd0, bus_or(1, 12)}, 64'h00);
        check("t1_bit5",   bit_mask(5, 45), 64'h0000_0000_0049_2001);
        check("t1_bit0",   bit_mask(0, 45), 64'h0000_0000_0124_8000);
        check("t1_bit3",   bit_mask(3, 45), 64'h0000_0000_0200_0000);
        check("t1_unused", {56'd0, bus_or(0, 44) & 8'h56}, 64'h00);
        check("t1_done_at", 64'(first_done(45)), 64'd40);
        check("t1_busy40", {63'd0, busy_t[40]}, 64'd1);
        check("t1_busy41", {63'd0, busy_t[41]}, 64'd0);

        // 2: three back-to-back pixels, period below natural length
        load_cfg(16'd4, 16'd10, 16'd3, 8'd3);
        run_frame(80);
        check("t2_bus25",  {56'd0, bus_t[25]}, 64'h28);
        check("t2_bus38",  {56'd0, bus_t[38]}, 64'h20);
        check("t2_bus40",  {56'd0, bus_t[40]}, 64'h01);
        check("t2_bus50",  {56'd0, bus_t[50]}, 64'h28);
        check("t2_bus75",  {56'd0, bus_t[75]}, 64'h08);
        check("t2_pix24",  {48'd0, pix_t[24]}, 64'd0);
        check("t2_pix25",  {48'd0, pix_t[25]}, 64'd1);
        check("t2_pix50",  {48'd0, pix_t[50]}, 64'd2);
        check("t2_pix74",  {48'd0, pix_t[74]}, 64'd2);
        check("t2_pix75",  {48'd0, pix_t[75]}, 64'd0);
        check("t2_done_at", 64'(first_done(80)), 64'd75);
        check("t2_done_n",  64'(done_count(80)), 64'd1);
        check("t2_n_bit5",  64'(bit_count(5, 80)), 64'd15);
        check("t2_n_bit0",  64'(bit_count(0, 80)), 64'd12);
        check("t2_n_bit7",  64'(bit_count(7, 80)), (MARK != 8'h00) ? 64'd1 : 64'd0);

        // 3: div 0 and div 1 both give spacing 2
        load_cfg(16'd4, 16'd10, 16'd1, 8'd0);
        run_frame(30);
        check("t3_d0_bit5", bit_mask(5, 30), 64'h0000_0000_000A_A001);
        check("t3_d0_bit0", bit_mask(0, 30), 64'h0000_0000_002A_8000);
        check("t3_d0_bit3", bit_mask(3, 30), 64'h0000_0000_0040_0000);
        check("t3_d0_done", 64'(first_done(30)), 64'd22);
        load_cfg(16'd4, 16'd10, 16'd1, 8'd1);
        run_frame(30);
        check("t3_d1_bit5", bit_mask(5, 30), 64'h0000_0000_000A_A001);
        check("t3_d1_bit0", bit_mask(0, 30), 64'h0000_0000_002A_8000);
        check("t3_d1_done", 64'(first_done(30)), 64'd22);

        // 4: abort three cycles into READ
        load_cfg(16'd4, 16'd40, 16'd1, 8'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        check("t4_read3", {56'd0, cdsbus}, 64'h20);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_ab_bus",  {56'd0, cdsbus}, 64'h08);
        check("t4_ab_done", {63'd0, done}, 64'd1);
        step();
        check("t4_idle_busy", {63'd0, busy}, 64'd0);
        check("t4_idle_bus",  {56'd0, cdsbus}, 64'h00);
        check("t4_idle_done", {63'd0, done}, 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_restart_bus",  {56'd0, cdsbus}, {56'd0, START_EXP});
        check("t4_restart_busy", {63'd0, busy}, 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_ab2_done", {63'd0, done}, 64'd1);
        step();
        check("t4_ab2_busy", {63'd0, busy}, 64'd0);

        // 5: start and cfg_load while busy are ignored
        load_cfg(16'd4, 16'd10, 16'd1, 8'd3);
        start = 1'b1;
        step();
        cfg_window = 16'd9;
        cfg_load   = 1'b1;
        step();
        start    = 1'b0;
        cfg_load = 1'b0;
        capture(40);
        check("t5_done_at", 64'(first_done(40)), 64'd24);
        check("t5_n_bit5",  64'(bit_count(5, 40)), 64'd4);
        check("t5_busy_end", {63'd0, busy_t[39]}, 64'd0);
        run_frame(30);
        check("t5_keep_done", 64'(first_done(30)), 64'd25);
        load_cfg(16'd9, 16'd10, 16'd1, 8'd3);
        run_frame(50);
        check("t5_new_done", 64'(first_done(50)), 64'd45);
        check("t5_new_bit5", 64'(bit_count(5, 50)), 64'd10);

        // 6: reset mid-INTEG, then a frame on the default config
        load_cfg(16'd4, 16'd10, 16'd2, 8'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("t6_integ_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_bus",  {56'd0, cdsbus}, 64'h00);
        check("t6_rst_busy", {63'd0, busy}, 64'd0);
        check("t6_rst_done", {63'd0, done}, 64'd0);
        check("t6_rst_pix",  {48'd0, pix_count}, 64'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        done_at = -1;
        n5 = 0;
        for (int i = 0; i < 1200; i++) begin
            if (cdsbus[5]) n5++;
            if (done) begin
                done_at = i;
                break;
            end
            step();
        end
        check("t6_def_done", 64'(done_at), 64'd1024);
        check("t6_def_bit5", 64'(n5), 64'd201);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
